// File: rtl/window_line_buffer.sv
// Sliding-window line buffer: streams a frame row by row and emits a vertical
// column of ROWS words (newest row in the low slice) for every word from row ROWS-1 on.
module window_line_buffer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_WIDTH = 8192,
  parameter int unsigned ROWS      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            cfg_width,
  input  logic [15:0]            cfg_height,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ROWS*DATA_W-1:0] m_col,
  output logic                   m_last_col,
  output logic                   m_last_row,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int unsigned COL_W  = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned NSTORE = ROWS - 1;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t            state, state_nx;
  logic [COL_W-1:0]  col, col_last;
  logic [15:0]       row, row_last;
  logic              tail;
  logic              accept, cfg_ok, end_col, prime_end, final_xfer;
  logic [DATA_W-1:0] data_q;
  logic              wr_pend;
  logic [COL_W-1:0]  wr_addr;

  assign cfg_ok     = (cfg_width != 32'd0) && (cfg_width <= 32'(MAX_WIDTH)) &&
                      (cfg_height >= 16'(ROWS));
  assign s_ready    = busy && !tail && (!m_valid || m_ready);
  assign accept     = s_valid && s_ready;
  assign end_col    = (col == col_last);
  assign prime_end  = accept && end_col && (row == 16'(ROWS - 2));
  assign final_xfer = (state == STREAM) && tail && m_valid && m_ready;
  assign done       = final_xfer;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && cfg_ok) state_nx = PRIME;
      PRIME:   if (prime_end) state_nx = STREAM;
      STREAM:  if (final_xfer) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Config latch, column/row position and end-of-input tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      col_last <= '0;
      row_last <= '0;
      tail     <= 1'b0;
      cfg_err  <= 1'b0;
    end else if (state == IDLE && start) begin
      cfg_err <= !cfg_ok;
      if (cfg_ok) begin
        col_last <= COL_W'(cfg_width - 32'd1);
        row_last <= cfg_height - 16'd1;
        col      <= '0;
        row      <= '0;
        tail     <= 1'b0;
      end
    end else if (accept) begin
      if (end_col) begin
        col <= '0;
        row <= row + 16'd1;
        if (row == row_last) tail <= 1'b1;
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Output handshake register; newest word is held locally, older rows come from the stores
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_last_col <= 1'b0;
      m_last_row <= 1'b0;
      data_q     <= '0;
      wr_pend    <= 1'b0;
      wr_addr    <= '0;
    end else begin
      wr_pend <= accept;
      if (accept) begin
        data_q  <= s_data;
        wr_addr <= col;
      end
      if (accept && state == STREAM) begin
        m_valid    <= 1'b1;
        m_last_col <= end_col;
        m_last_row <= (row == row_last);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign m_col[DATA_W-1:0] = data_q;

  // Row stores: store 0 takes the new word at accept; deeper stores take the
  // word shifted out of the store above one cycle later, with a bypass for width 1.
  for (genvar i = 0; i < NSTORE; i++) begin : g_store
    logic [DATA_W-1:0] mem [MAX_WIDTH];
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] wdata;
    logic [COL_W-1:0]  waddr;
    logic              we;
    logic [DATA_W-1:0] rnext;

    if (i == 0) begin : g_head
      assign we    = accept;
      assign waddr = col;
      assign wdata = s_data;
      assign rnext = mem[col];
    end else begin : g_shift
      assign we    = wr_pend;
      assign waddr = wr_addr;
      assign wdata = g_store[i-1].rd;
      assign rnext = (wr_pend && wr_addr == col) ? g_store[i-1].rd : mem[col];
    end

    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
      if (rst)         rd <= '0;
      else if (accept) rd <= rnext;
    end

    assign m_col[(i+1)*DATA_W +: DATA_W] = rd;
  end

endmodule
